// File: rtl/clause_eval_k.sv
// Clause evaluator: replicated truth table, per-clause literal count and
// per-occurrence-list break count against a latched candidate variable.
//   state    | meaning
//   S_IDLE   | waiting for the first clause of a list
//   S_ACCUM  | clauses of a list in flight, breaks accumulating
//   S_REPORT | one-cycle break report for the finished list
module clause_eval_k #(
  parameter int K      = 3,
  parameter int VAR_AW = 11,
  parameter int BRK_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [K*VAR_AW-1:0]      lit_addr,
  input  logic [K-1:0]             lit_neg,
  input  logic                     in_last,
  input  logic [VAR_AW-1:0]        cand_addr,
  input  logic                     flip_en,
  input  logic [VAR_AW-1:0]        flip_addr,
  input  logic                     flip_value,
  output logic                     res_valid,
  output logic                     clause_sat,
  output logic [$clog2(K+1)-1:0]   true_cnt,
  output logic                     brk_valid,
  output logic [BRK_W-1:0]         brk,
  output logic                     brk_sat
);

  localparam int CW    = $clog2(K+1);
  localparam int DEPTH = 1 << VAR_AW;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPORT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                r_rst_done;
  logic                r_got_last;
  logic [VAR_AW-1:0]   r_cand;

  logic                r_tbl [K][DEPTH];
  logic [K-1:0]        r_s1_rd;
  logic                r_s1_valid;
  logic [K-1:0]        r_s1_neg;
  logic [K*VAR_AW-1:0] r_s1_addr;
  logic                r_s1_last;

  logic [K-1:0]        w_lit;
  logic [CW-1:0]       w_cnt;
  logic                w_hit;
  logic                w_brk;

  logic                r_res_valid;
  logic                r_clause_sat;
  logic [CW-1:0]       r_true_cnt;
  logic                r_s2_brk;
  logic                r_s2_last;

  logic [BRK_W-1:0]    r_cnt;
  logic                r_sat;
  logic [BRK_W:0]      w_sum;
  logic [BRK_W-1:0]    w_cnt_nxt;
  logic                w_sat_nxt;
  logic [BRK_W-1:0]    r_brk;
  logic                r_brk_sat;

  assign w_accept = in_valid & in_ready;

  // Table banks carry no reset; only flip writes change them.
  always_ff @(posedge clk) begin
    if (flip_en) begin
      for (int b = 0; b < K; b++) begin
        r_tbl[b][flip_addr] <= flip_value;
      end
    end
  end

  // Same-cycle flip to the address being read wins over the stored bit.
  always_ff @(posedge clk) begin
    for (int b = 0; b < K; b++) begin
      r_s1_rd[b] <= (flip_en && (flip_addr == lit_addr[b*VAR_AW +: VAR_AW])) ?
                    flip_value : r_tbl[b][lit_addr[b*VAR_AW +: VAR_AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_neg   <= '0;
      r_s1_addr  <= '0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_neg  <= lit_neg;
        r_s1_addr <= lit_addr;
        r_s1_last <= in_last;
      end
    end
  end

  always_comb begin
    w_lit = r_s1_rd ^ r_s1_neg;
    w_cnt = '0;
    w_hit = 1'b0;
    for (int i = 0; i < K; i++) begin
      w_cnt = w_cnt + CW'(w_lit[i]);
      if (w_lit[i] && (r_s1_addr[i*VAR_AW +: VAR_AW] == r_cand)) begin
        w_hit = 1'b1;
      end
    end
    w_brk = (w_cnt == CW'(1)) && w_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_res_valid  <= 1'b0;
      r_clause_sat <= 1'b0;
      r_true_cnt   <= '0;
      r_s2_brk     <= 1'b0;
      r_s2_last    <= 1'b0;
    end else begin
      r_res_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_clause_sat <= (w_cnt != '0);
        r_true_cnt   <= w_cnt;
        r_s2_brk     <= w_brk;
        r_s2_last    <= r_s1_last;
      end
    end
  end

  // in_ready stays low while reset is held, even though the state is IDLE.
  always_ff @(posedge clk) begin
    r_rst_done <= rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ACCUM;
      S_ACCUM:  if (r_res_valid && r_s2_last) w_state_nxt = S_REPORT;
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = r_rst_done && ((r_state == S_IDLE) ||
                               ((r_state == S_ACCUM) && !r_got_last));
    brk_valid = (r_state == S_REPORT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_got_last <= 1'b0;
      r_cand     <= '0;
    end else begin
      if (w_accept && in_last) begin
        r_got_last <= 1'b1;
      end else if (r_state == S_REPORT) begin
        r_got_last <= 1'b0;
      end
      if ((r_state == S_IDLE) && w_accept) begin
        r_cand <= cand_addr;
      end
    end
  end

  assign w_sum     = {1'b0, r_cnt} + {{BRK_W{1'b0}}, r_s2_brk};
  assign w_cnt_nxt = w_sum[BRK_W] ? {BRK_W{1'b1}} : w_sum[BRK_W-1:0];
  assign w_sat_nxt = r_sat | w_sum[BRK_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_brk     <= '0;
      r_brk_sat <= 1'b0;
    end else if ((r_state == S_IDLE) && w_accept) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if ((r_state == S_ACCUM) && r_res_valid) begin
      r_cnt <= w_cnt_nxt;
      r_sat <= w_sat_nxt;
      if (r_s2_last) begin
        r_brk     <= w_cnt_nxt;
        r_brk_sat <= w_sat_nxt;
      end
    end
  end

  assign res_valid  = r_res_valid;
  assign clause_sat = r_clause_sat;
  assign true_cnt   = r_true_cnt;
  assign brk        = r_brk;
  assign brk_sat    = r_brk_sat;

endmodule

// File: tb/tb_clause_eval_k.sv
// Randomized and directed bench for clause_eval_k, checked against a
// cycle-scheduled reference model of clause results and list breaks.
module tb_clause_eval_k;

  localparam int K      = 3;
  localparam int VAR_AW = 11;
  localparam int BRK_W  = 8;
  localparam int CW     = $clog2(K+1);
  localparam int DEPTH  = 1 << VAR_AW;
  localparam int BRK_MAX = (1 << BRK_W) - 1;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [K*VAR_AW-1:0] lit_addr;
  logic [K-1:0]        lit_neg;
  logic                in_last;
  logic [VAR_AW-1:0]   cand_addr;
  logic                flip_en;
  logic [VAR_AW-1:0]   flip_addr;
  logic                flip_value;
  logic                res_valid;
  logic                clause_sat;
  logic [CW-1:0]       true_cnt;
  logic                brk_valid;
  logic [BRK_W-1:0]    brk;
  logic                brk_sat;

  clause_eval_k #(.K(K), .VAR_AW(VAR_AW), .BRK_W(BRK_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .lit_addr(lit_addr), .lit_neg(lit_neg), .in_last(in_last),
    .cand_addr(cand_addr),
    .flip_en(flip_en), .flip_addr(flip_addr), .flip_value(flip_value),
    .res_valid(res_valid), .clause_sat(clause_sat), .true_cnt(true_cnt),
    .brk_valid(brk_valid), .brk(brk), .brk_sat(brk_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; int v; int s; } ev_t;
  ev_t res_q[$];
  ev_t brk_q[$];
  bit  mtbl [DEPTH];
  int  cyc = 0;
  bit  m_ready = 1'b0;
  bit  m_rst_done = 1'b0;
  bit  m_in_rst = 1'b0;
  int  m_block = 0;
  bit  in_list = 1'b0;
  int  m_cand = 0;
  int  nbrk = 0;
  int  h_cnt = 0, h_brk = 0, h_bsat = 0;
  int  n_resv = 0, n_brkv = 0;

  task automatic model_step();
    bit acc;
    int cnt, a, ta;
    if (flip_en) mtbl[flip_addr] = flip_value;
    cyc++;
    m_in_rst = !rst;
    if (!rst) begin
      m_rst_done = 1'b0;
      m_block = 0;
      in_list = 1'b0;
      res_q.delete();
      brk_q.delete();
    end else begin
      acc = in_valid && m_ready;
      if (m_block > 0) m_block--;
      if (acc) begin
        if (!in_list) begin
          in_list = 1'b1;
          m_cand  = int'(cand_addr);
          nbrk    = 0;
        end
        cnt = 0;
        ta  = -1;
        for (int i = 0; i < K; i++) begin
          a = int'(lit_addr[i*VAR_AW +: VAR_AW]);
          if (mtbl[a] ^ lit_neg[i]) begin
            cnt++;
            ta = a;
          end
        end
        if (cnt == 1 && ta == m_cand) nbrk++;
        res_q.push_back('{cyc + 1, cnt, 0});
        if (in_last) begin
          brk_q.push_back('{cyc + 2, (nbrk > BRK_MAX) ? BRK_MAX : nbrk,
                            (nbrk > BRK_MAX) ? 1 : 0});
          in_list = 1'b0;
          m_block = 3;
        end
      end
      m_rst_done = 1'b1;
    end
    m_ready = m_rst_done && (m_block == 0);
  endtask

  task automatic monitor_step();
    bit erv, ebv;
    if (m_in_rst) begin
      h_cnt = 0; h_brk = 0; h_bsat = 0;
    end
    erv = (res_q.size() > 0) && (res_q[0].cyc == cyc);
    ebv = (brk_q.size() > 0) && (brk_q[0].cyc == cyc);
    if (erv) begin
      h_cnt = res_q[0].v;
      void'(res_q.pop_front());
    end
    if (ebv) begin
      h_brk  = brk_q[0].v;
      h_bsat = brk_q[0].s;
      void'(brk_q.pop_front());
    end
    if (res_valid) n_resv++;
    if (brk_valid) n_brkv++;
    chk("res_valid",  int'(res_valid),  int'(erv));
    chk("true_cnt",   int'(true_cnt),   h_cnt);
    chk("clause_sat", int'(clause_sat), (h_cnt != 0) ? 1 : 0);
    chk("brk_valid",  int'(brk_valid),  int'(ebv));
    chk("brk",        int'(brk),        h_brk);
    chk("brk_sat",    int'(brk_sat),    h_bsat);
    chk("in_ready",   int'(in_ready),   int'(m_ready));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      monitor_step();
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [K*VAR_AW-1:0] pk(input int a0, input int a1, input int a2);
    return {VAR_AW'(a2), VAR_AW'(a1), VAR_AW'(a0)};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flip(input int a, input bit v);
    flip_en = 1'b1; flip_addr = VAR_AW'(a); flip_value = v;
    idle(1);
    flip_en = 1'b0;
  endtask

  task automatic send(input logic [K*VAR_AW-1:0] a, input logic [K-1:0] n,
                      input bit last, input int c, output int waited);
    waited = 0;
    while (!m_ready && waited < 50) begin
      idle(1);
      waited++;
    end
    if (!m_ready) begin
      chk("ready_timeout", 0, 1);
    end else begin
      in_valid = 1'b1; lit_addr = a; lit_neg = n; in_last = last;
      cand_addr = VAR_AW'(c);
      idle(1);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  int w, stalls, b0, r0;

  initial begin
    rst = 1'b0; in_valid = 1'b0; lit_addr = '0; lit_neg = '0; in_last = 1'b0;
    cand_addr = '0; flip_en = 1'b0; flip_addr = '0; flip_value = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    for (int a = 0; a < DEPTH; a++) flip(a, 1'($urandom % 2));

    // single-clause list that breaks
    flip(1, 1); flip(2, 0); flip(3, 0);
    send(pk(1, 2, 3), 3'b000, 1'b1, 1, w);
    idle(5);
    chk("r030_brk", int'(brk), 1);
    chk("r030_cnt", int'(true_cnt), 1);

    // four-clause list, two breaks
    flip(5, 1); flip(8, 0); flip(9, 0); flip(10, 1); flip(11, 1);
    send(pk(5, 8, 9),  3'b000, 1'b0, 5, w);
    send(pk(9, 5, 8),  3'b000, 1'b0, 0, w);
    send(pk(5, 10, 8), 3'b000, 1'b0, 0, w);
    send(pk(8, 9, 8),  3'b000, 1'b1, 0, w);
    idle(5);
    chk("r031_brk", int'(brk), 2);

    // flip in the accept cycle is seen by the clause
    flip(7, 0);
    flip_en = 1'b1; flip_addr = VAR_AW'(7); flip_value = 1'b1;
    send(pk(7, 7, 7), 3'b000, 1'b1, 7, w);
    flip_en = 1'b0;
    idle(5);
    chk("r032_cnt", int'(true_cnt), 3);
    chk("r032_brk", int'(brk), 0);

    // saturation
    for (int i = 0; i < 300; i++) send(pk(5, 8, 9), 3'b000, (i == 299), 5, w);
    idle(5);
    chk("r033_brk", int'(brk), 255);
    chk("r033_sat", int'(brk_sat), 1);

    // reset mid-list drops the partial count
    send(pk(5, 8, 9), 3'b000, 1'b0, 5, w);
    send(pk(5, 8, 9), 3'b000, 1'b0, 5, w);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    b0 = n_brkv;
    send(pk(5, 8, 9), 3'b000, 1'b1, 5, w);
    idle(6);
    chk("r034_pulses", n_brkv - b0, 1);
    chk("r034_brk", int'(brk), 1);
    chk("r034_sat", int'(brk_sat), 0);

    // back-to-back list of 16
    r0 = n_resv;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      send(pk($urandom % 12, $urandom % 12, $urandom % 12), 3'($urandom),
           (i == 15), $urandom % 12, w);
      if (i > 0) stalls += w;
    end
    idle(6);
    chk("r035_stalls", stalls, 0);
    chk("r035_results", n_resv - r0, 16);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom % 4) != 0;
      for (int i = 0; i < K; i++) begin
        lit_addr[i*VAR_AW +: VAR_AW] = (($urandom % 8) == 0) ?
                                       VAR_AW'($urandom % DEPTH) : VAR_AW'($urandom % 12);
      end
      lit_neg    = K'($urandom);
      in_last    = ($urandom % 6) == 0;
      cand_addr  = VAR_AW'($urandom % 12);
      flip_en    = ($urandom % 3) == 0;
      flip_addr  = VAR_AW'($urandom % 12);
      flip_value = 1'($urandom % 2);
      idle(1);
    end
    in_valid = 1'b0; flip_en = 1'b0; in_last = 1'b0;
    idle(10);
    chk("drain_res_q", res_q.size(), 0);
    chk("drain_brk_q", brk_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clause_eval_k.md
CLAUSE_EVAL_K -- requirements
Module: clause_eval_k

Interface
REQ-001 SHALL provide parameter K, default 3: literals per clause (2..8).
REQ-002 SHALL provide parameter VAR_AW, default 11: variable address width; table depth 2**VAR_AW.
REQ-003 SHALL provide parameter BRK_W, default 8: break counter width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 in_valid  in  1  clause literals present.
REQ-007 in_ready  out  1  clause accepted when in_valid&in_ready.
REQ-008 lit_addr  in  K*VAR_AW  literal i variable address at [i*VAR_AW +: VAR_AW].
REQ-009 lit_neg  in  K  literal i negated when bit i=1.
REQ-010 in_last  in  1  last clause of current occurrence list.
REQ-011 cand_addr  in  VAR_AW  candidate variable; sampled with first clause of each list.
REQ-012 flip_en / flip_addr / flip_value  in  1 / VAR_AW / 1  truth-table write port.
REQ-013 res_valid / clause_sat / true_cnt  out  1 / 1 / $clog2(K+1)  per-clause result.
REQ-014 brk_valid / brk / brk_sat  out  1 / BRK_W / 1  per-list break result.

Function
REQ-015 SHALL hold a 2**VAR_AW x 1 truth table replicated in K banks, each written identically by the flip port; K reads per cycle.
REQ-016 SHALL not reset table contents; table state is changed only by flip writes.
REQ-017 Literal value = table[lit_addr_i] XOR lit_neg_i; true_cnt = count of true literals; clause_sat = (true_cnt != 0).
REQ-018 Duplicate addresses within one clause SHALL be evaluated independently (no merging).
REQ-019 Pipeline: accept (cycle 0) -> table read (cycle 1) -> res_valid pulse with results (cycle 2); one clause per cycle throughput.
REQ-020 A flip write to address A in the accept cycle of a clause reading A SHALL be visible to that clause (write-first bypass).
REQ-021 Clause breaks candidate when true_cnt==1 and the single true literal has lit_addr == latched cand_addr.
REQ-022 FSM states IDLE, ACCUM, REPORT; IDLE->ACCUM on first accept (latch cand_addr, clear count); ACCUM->REPORT when the in_last clause's result is produced; REPORT->IDLE after one cycle.
REQ-023 in_ready SHALL be 1 in IDLE and ACCUM until an in_last clause is accepted, then 0 until return to IDLE.
REQ-024 brk_valid SHALL pulse one cycle in REPORT with brk = number of breaking clauses in the list, including the in_last clause.
REQ-025 brk SHALL saturate at 2**BRK_W-1; brk_sat=1 with brk_valid if saturation occurred, else 0.
REQ-026 A single clause with in_last in IDLE SHALL form a complete list of length 1.
REQ-027 brk, brk_sat, clause_sat, true_cnt SHALL hold last values when their valid is low.

Reset
REQ-028 With rst=0 at a clk edge: state IDLE, in_ready 0 during reset then 1 the cycle after release, res_valid 0, brk_valid 0, brk 0, brk_sat 0, clause_sat 0, true_cnt 0, in-flight clauses discarded.
REQ-029 Reset mid-list SHALL drop the partial count; no brk_valid for that list.

Verification (K=3, VAR_AW=11, BRK_W=8)
REQ-030 Flip vars 1,2,3 to 1,0,0; clause (1,2,3) no negation, in_last, cand=1 -> cycle+2 res_valid, true_cnt=1, clause_sat=1; brk_valid next cycle, brk=1.
REQ-031 List of 4 clauses, cand=5, var5=1, two clauses with only var5 true, one with 2 true, one unsat -> brk=2, in_ready low from in_last accept until IDLE.
REQ-032 Flip var7 0->1 same cycle as clause (7,7,7) lit_neg=000 accepted -> true_cnt=3, clause_sat=1, brk=0.
REQ-033 300 breaking clauses in one list -> brk=255, brk_sat=1.
REQ-034 Assert rst=0 after 2 of 3 clauses, release, send single in_last clause -> only one brk_valid, reflecting that clause alone.
REQ-035 Back-to-back clauses every cycle for 16 clauses -> 16 consecutive res_valid pulses, no stall before in_last.
